request_arbiter_queue: RTL and testbench
========================================

# request_arbiter_queue

Buffered multi-requester front end for the round-robin arbiter. Each of NUM_REQUESTERS sources pushes transactions into its own small FIFO. A round-robin grant selects one non-empty FIFO per cycle, and the winner moves into a registered output stage with a valid/ready handshake toward the shared downstream consumer. The block turns the arbiter's combinational grant into a flow-controlled, fair, back-pressured stream.

## Interface
- NUM_REQUESTERS, 4, number of sources; must be ≥2.
- DATA_WIDTH, 32, payload width.
- FIFO_DEPTH, 2, entries per source FIFO; must be a power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  NUM_REQUESTERS  per-source push request.
- req_data  in  NUM_REQUESTERS×DATA_WIDTH  per-source payload.
- req_ready  out  NUM_REQUESTERS  per-source FIFO not full.
- out_valid  out  1  output register holds a transaction.
- out_data  out  DATA_WIDTH  payload of the held transaction.
- out_id  out  $clog2(NUM_REQUESTERS)  source index of the held transaction.
- out_ready  in  1  consumer accepts the transaction this cycle.

## Operation
- Push to FIFO i when req_valid[i] && req_ready[i].
- req_ready[i] = !full[i], taken from registered occupancy. There is no same-cycle bypass: a full FIFO that pops this cycle still shows req_ready low.
- Arbiter request vector = ~empty (per FIFO).
- load = !out_valid || out_ready.
- On load with any grant: pop the granted FIFO, capture its head into out_data, write the grant index to out_id, set out_valid.
- On load with no grant: clear out_valid.
- When load is 0, the output register and all FIFO read pointers hold.
- Arbiter state (update_lru) advances only on a cycle where load=1 and a grant exists. A stalled output never rotates priority.
- Priority rule: after granting i, the search order starts at i+1, wrapping modulo NUM_REQUESTERS. After reset, priority starts at index 0.
- Grant is one-hot and encoded to out_id. Non-requesting sources are skipped with no idle cycle.
- Occupancy counters are $clog2(FIFO_DEPTH)+1 bits wide. Pointers wrap modulo FIFO_DEPTH.
- A simultaneous push and pop on the same non-full FIFO leaves its count unchanged.
- Reset, including mid-operation, empties all FIFOs, clears out_valid, and returns priority to index 0. In-flight data is discarded.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_id=0.
  - req_ready = all ones, asserted during and after reset.
  - All FIFOs empty; arbiter pointer at 0.
- Latency: a push accepted on edge t makes the FIFO non-empty at t+1. With an idle output and out_ready high, out_valid is asserted after edge t+1 (2 cycles from push to output).
- Throughput: one transaction per cycle while out_ready=1 and any FIFO is non-empty.
- While out_valid && !out_ready, out_data and out_id are stable.
- req_ready[i] falls the cycle after the push that fills FIFO i. It rises the cycle after the pop that frees a slot.
- All outputs are registered, with no combinational path from req_* or out_ready to any output.

## Test plan
- Single source: push 0xA5 on source 2 at cycle 0, out_ready=1 → out_valid=1, out_data=0xA5, out_id=2 at cycle 2; out_valid=0 at cycle 3.
- Fairness: preload all four FIFOs with two entries each, then hold out_ready=1 → out_id sequence 0,1,2,3,0,1,2,3, back to back; out_valid low afterwards.
- Sparse requests: only sources 0 and 2 loaded with data 0x10,0x11 and 0x20,0x21 → out_id 0,2,0,2 with data 0x10,0x20,0x11,0x21, no bubbles.
- Backpressure: fill all FIFOs and hold out_ready=0 for 5 cycles → out_id=0 and its data held stable. Releasing out_ready gives out_id 1 next, proving priority did not rotate during the stall. req_ready=0 on every full source.
- Full FIFO: push two entries to source 1 with the output stalled → req_ready[1]=0 from the cycle after the second push. A third req_valid is not accepted and its data never appears at the output.
- Reset mid-stream: deassert reset_n while FIFOs hold data and out_valid=1 → out_valid=0 immediately (async) and req_ready all ones. After release, a push on source 3 emerges alone with out_id=3, and a subsequent all-source load starts at out_id 0.

Source files
------------

// File: rtl/request_arbiter_queue.sv
// request_arbiter_queue: per-source FIFOs feeding a round-robin arbiter and a
// registered valid/ready output stage.
module request_arbiter_queue #(
    parameter int NUM_REQUESTERS = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 2
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic [NUM_REQUESTERS-1:0]              req_valid,
    input  logic [NUM_REQUESTERS*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQUESTERS-1:0]              req_ready,
    output logic                                   out_valid,
    output logic [DATA_WIDTH-1:0]                  out_data,
    output logic [$clog2(NUM_REQUESTERS)-1:0]      out_id,
    input  logic                                   out_ready
);
    localparam int N  = NUM_REQUESTERS;
    localparam int IW = $clog2(N);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_WIDTH-1:0] r_mem [N][FIFO_DEPTH];
    logic [PW-1:0]         r_wptr [N];
    logic [PW-1:0]         r_rptr [N];
    logic [CW-1:0]         r_cnt [N];
    logic [IW-1:0]         r_prio;

    logic [N-1:0] w_push, w_pop, w_full, w_nonempty;
    logic         w_load, w_gnt;
    logic [IW-1:0] w_gidx;
    logic [IW:0]   w_idx;

    always_comb begin
        w_full     = '0;
        w_nonempty = '0;
        w_push     = '0;
        for (int i = 0; i < N; i++) begin
            w_full[i]     = r_cnt[i] == CW'(FIFO_DEPTH);
            w_nonempty[i] = r_cnt[i] != '0;
            w_push[i]     = req_valid[i] && !w_full[i];
        end
    end

    // Search starts at r_prio and wraps; the first non-empty FIFO wins.
    always_comb begin
        w_gnt  = 1'b0;
        w_gidx = '0;
        w_idx  = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = {1'b0, r_prio} + (IW+1)'(k);
            if (w_idx >= (IW+1)'(N))
                w_idx = w_idx - (IW+1)'(N);
            if (!w_gnt && w_nonempty[w_idx[IW-1:0]]) begin
                w_gnt  = 1'b1;
                w_gidx = w_idx[IW-1:0];
            end
        end
    end

    assign w_load    = !out_valid || out_ready;
    assign req_ready = ~w_full;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N; i++)
            w_pop[i] = w_load && w_gnt && (w_gidx == IW'(i));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            r_prio    <= '0;
            for (int i = 0; i < N; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
                r_cnt[i]  <= '0;
            end
        end else begin
            if (w_load) begin
                out_valid <= w_gnt;
                if (w_gnt) begin
                    out_data <= r_mem[w_gidx][r_rptr[w_gidx]];
                    out_id   <= w_gidx;
                    r_prio   <= (w_gidx == IW'(N-1)) ? '0 : w_gidx + 1'b1;
                end
            end
            for (int i = 0; i < N; i++) begin
                if (w_push[i])
                    r_wptr[i] <= r_wptr[i] + 1'b1;
                if (w_pop[i])
                    r_rptr[i] <= r_rptr[i] + 1'b1;
                r_cnt[i] <= r_cnt[i] + CW'(w_push[i]) - CW'(w_pop[i]);
            end
        end
    end

    // Payload storage needs no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++)
            if (w_push[i])
                r_mem[i][r_wptr[i]] <= req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
endmodule

// File: tb/tb_request_arbiter_queue.sv
// tb_request_arbiter_queue: directed and random checks of request_arbiter_queue
// against a queue-based reference model.
module tb_request_arbiter_queue;
    localparam int N     = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic [1:0]      out_id;
    logic            out_ready;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] q [N][$];
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [1:0]    m_id;
    int            m_prio;
    logic [1:0]    acc_id [$];
    logic [DW-1:0] acc_data [$];

    request_arbiter_queue #(.NUM_REQUESTERS(N), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
        .out_id(out_id), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [N*DW-1:0] pk(input logic [DW-1:0] a, b, c, d);
        return {d, c, b, a};
    endfunction

    task automatic model_reset;
        for (int i = 0; i < N; i++) q[i].delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_id    = '0;
        m_prio  = 0;
        acc_id.delete();
        acc_data.delete();
    endtask

    // One clock: drive, log accepted transfer, advance model, compare outputs.
    task automatic step(input logic [N-1:0] v, input logic [N*DW-1:0] d, input logic rdy);
        logic         ld;
        int           w;
        logic [N-1:0] rd;
        logic [N-1:0] exp_rdy;
        req_valid = v;
        req_data  = d;
        out_ready = rdy;
        if (out_valid && rdy) begin
            acc_id.push_back(out_id);
            acc_data.push_back(out_data);
        end
        @(posedge clk);
        ld = !m_valid || rdy;
        w  = -1;
        for (int k = 0; k < N; k++) begin
            int j = (m_prio + k) % N;
            if (w < 0 && q[j].size() > 0) w = j;
        end
        for (int i = 0; i < N; i++) rd[i] = q[i].size() < DEPTH;
        if (ld) begin
            if (w >= 0) begin
                m_data  = q[w].pop_front();
                m_id    = 2'(w);
                m_valid = 1'b1;
                m_prio  = (w + 1) % N;
            end else
                m_valid = 1'b0;
        end
        for (int i = 0; i < N; i++)
            if (v[i] && rd[i]) q[i].push_back(d[i*DW +: DW]);
        for (int i = 0; i < N; i++) exp_rdy[i] = q[i].size() < DEPTH;
        #1;
        checks++;
        if (out_valid !== m_valid) begin
            errors++;
            $display("FAIL model out_valid @%0t: got %b expected %b", $time, out_valid, m_valid);
        end
        checks++;
        if (out_id !== m_id) begin
            errors++;
            $display("FAIL model out_id @%0t: got %0d expected %0d", $time, out_id, m_id);
        end
        checks++;
        if (out_data !== m_data) begin
            errors++;
            $display("FAIL model out_data @%0t: got %h expected %h", $time, out_data, m_data);
        end
        checks++;
        if (req_ready !== exp_rdy) begin
            errors++;
            $display("FAIL model req_ready @%0t: got %b expected %b", $time, req_ready, exp_rdy);
        end
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_id !== '0) begin
            errors++;
            $display("FAIL reset outputs: got v=%b d=%h id=%0d expected 0/0/0", out_valid, out_data, out_id);
        end
        checks++;
        if (req_ready !== 4'hF) begin
            errors++;
            $display("FAIL reset req_ready during reset: got %b expected 1111", req_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        step('0, '0, 1'b1);
        checks++;
        if (req_ready !== 4'hF || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset after release: got rdy=%b v=%b expected 1111/0", req_ready, out_valid);
        end
    endtask

    task automatic test_single;
        do_reset();
        step(4'b0100, pk(0, 0, 32'hA5, 0), 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single cycle1 out_valid: got %b expected 0", out_valid);
        end
        step('0, '0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 32'hA5 || out_id !== 2'd2) begin
            errors++;
            $display("FAIL single cycle2: got v=%b d=%h id=%0d expected 1/a5/2", out_valid, out_data, out_id);
        end
        step('0, '0, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single cycle3 out_valid: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_fairness;
        do_reset();
        for (int e = 0; e < 2; e++)
            step(4'hF, pk(32'h100 + e, 32'h110 + e, 32'h120 + e, 32'h130 + e), 1'b0);
        for (int c = 0; c < 8; c++) step('0, '0, 1'b1);
        step('0, '0, 1'b1);
        checks++;
        if (acc_id.size() != 8) begin
            errors++;
            $display("FAIL fairness count: got %0d expected 8", acc_id.size());
        end
        for (int i = 0; i < acc_id.size() && i < 8; i++) begin
            checks++;
            if (acc_id[i] !== 2'(i % 4) || acc_data[i] !== 32'(32'h100 + 32'h10 * (i % 4) + i / 4)) begin
                errors++;
                $display("FAIL fairness seq[%0d]: got id=%0d d=%h expected id=%0d", i, acc_id[i], acc_data[i], i % 4);
            end
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL fairness drained out_valid: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_sparse;
        logic [1:0]    eid [4];
        logic [DW-1:0] edat [4];
        eid  = '{2'd0, 2'd2, 2'd0, 2'd2};
        edat = '{32'h10, 32'h20, 32'h11, 32'h21};
        do_reset();
        step(4'b0101, pk(32'h10, 0, 32'h20, 0), 1'b0);
        step(4'b0101, pk(32'h11, 0, 32'h21, 0), 1'b0);
        for (int c = 0; c < 4; c++) step('0, '0, 1'b1);
        checks++;
        if (acc_id.size() != 4) begin
            errors++;
            $display("FAIL sparse count: got %0d expected 4", acc_id.size());
        end
        for (int i = 0; i < acc_id.size() && i < 4; i++) begin
            checks++;
            if (acc_id[i] !== eid[i] || acc_data[i] !== edat[i]) begin
                errors++;
                $display("FAIL sparse seq[%0d]: got id=%0d d=%h expected id=%0d d=%h", i, acc_id[i], acc_data[i], eid[i], edat[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        do_reset();
        for (int e = 0; e < 3; e++)
            step(4'hF, pk(32'hB000_0000 + e, 32'hB000_0100 + e, 32'hB000_0200 + e, 32'hB000_0300 + e), 1'b0);
        for (int c = 0; c < 5; c++) begin
            step('0, '0, 1'b0);
            checks++;
            if (out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== 32'hB000_0000 || req_ready !== 4'h0) begin
                errors++;
                $display("FAIL backpressure hold %0d: got v=%b id=%0d d=%h rdy=%b expected 1/0/b0000000/0000",
                         c, out_valid, out_id, out_data, req_ready);
            end
        end
        step('0, '0, 1'b1);
        checks++;
        if (out_id !== 2'd1 || out_data !== 32'hB000_0100) begin
            errors++;
            $display("FAIL backpressure release: got id=%0d d=%h expected 1/b0000100", out_id, out_data);
        end
    endtask

    task automatic test_full;
        logic seen;
        do_reset();
        step(4'b0001, pk(32'h55, 0, 0, 0), 1'b0);
        step('0, '0, 1'b0);
        step(4'b0010, pk(0, 32'hB1, 0, 0), 1'b0);
        checks++;
        if (req_ready[1] !== 1'b1) begin
            errors++;
            $display("FAIL full after one push req_ready[1]: got %b expected 1", req_ready[1]);
        end
        step(4'b0010, pk(0, 32'hB2, 0, 0), 1'b0);
        checks++;
        if (req_ready[1] !== 1'b0) begin
            errors++;
            $display("FAIL full after two pushes req_ready[1]: got %b expected 0", req_ready[1]);
        end
        step(4'b0010, pk(0, 32'hDEAD, 0, 0), 1'b0);
        for (int c = 0; c < 5; c++) step('0, '0, 1'b1);
        seen = 1'b0;
        foreach (acc_data[i]) if (acc_data[i] === 32'hDEAD) seen = 1'b1;
        checks++;
        if (seen || acc_data.size() != 3) begin
            errors++;
            $display("FAIL full rejected push: got seen=%b count=%0d expected 0/3", seen, acc_data.size());
        end
    endtask

    task automatic test_reset_midstream;
        do_reset();
        step(4'hF, pk(1, 2, 3, 4), 1'b0);
        step(4'hF, pk(5, 6, 7, 8), 1'b1);
        step('0, '0, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || req_ready !== 4'hF || out_id !== 2'd0) begin
            errors++;
            $display("FAIL midstream reset: got v=%b rdy=%b id=%0d expected 0/1111/0", out_valid, req_ready, out_id);
        end
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(4'b1000, pk(0, 0, 0, 32'h33), 1'b1);
        step('0, '0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd3 || out_data !== 32'h33) begin
            errors++;
            $display("FAIL midstream src3: got v=%b id=%0d d=%h expected 1/3/33", out_valid, out_id, out_data);
        end
        step(4'hF, pk(32'h40, 32'h41, 32'h42, 32'h43), 1'b1);
        step('0, '0, 1'b1);
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== 32'h40) begin
            errors++;
            $display("FAIL midstream all-load: got v=%b id=%0d d=%h expected 1/0/40", out_valid, out_id, out_data);
        end
        for (int c = 0; c < 4; c++) step('0, '0, 1'b1);
    endtask

    task automatic test_random;
        do_reset();
        for (int c = 0; c < 400; c++)
            step(4'($urandom), {$urandom, $urandom, $urandom, $urandom}, ($urandom % 4) != 0);
        for (int c = 0; c < 12; c++) step('0, '0, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL random drain out_valid: got %b expected 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_sparse();
        test_backpressure();
        test_full();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
